// File: rtl/csr_regfile_pkg.sv
// Shared CSR address map, WARL masks and write-value helpers for csr_regfile.
package csr_regfile_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int CSR_ADDR_WIDTH = 12;

    typedef logic [CSR_ADDR_WIDTH-1:0] csr_addr_t;
    typedef logic [DATA_WIDTH-1:0]     csr_data_t;

    // Machine-mode CSR addresses
    localparam csr_addr_t CSR_MSTATUS       = 12'h300;
    localparam csr_addr_t CSR_MISA          = 12'h301;
    localparam csr_addr_t CSR_MIE           = 12'h304;
    localparam csr_addr_t CSR_MTVEC         = 12'h305;
    localparam csr_addr_t CSR_MCOUNTINHIBIT = 12'h320;
    localparam csr_addr_t CSR_MSCRATCH      = 12'h340;
    localparam csr_addr_t CSR_MEPC          = 12'h341;
    localparam csr_addr_t CSR_MCAUSE        = 12'h342;
    localparam csr_addr_t CSR_MIP           = 12'h344;
    localparam csr_addr_t CSR_MCYCLE        = 12'hB00;
    localparam csr_addr_t CSR_MINSTRET      = 12'hB02;
    localparam csr_addr_t CSR_MCYCLEH       = 12'hB80;
    localparam csr_addr_t CSR_MINSTRETH     = 12'hB82;
    localparam csr_addr_t CSR_CYCLE         = 12'hC00;
    localparam csr_addr_t CSR_INSTRET       = 12'hC02;
    localparam csr_addr_t CSR_CYCLEH        = 12'hC80;
    localparam csr_addr_t CSR_INSTRETH      = 12'hC82;
    localparam csr_addr_t CSR_MHARTID       = 12'hF14;

    // WARL masks: which bits software can change, plus bits that read as constant 1
    localparam csr_data_t MSTATUS_WMASK       = 32'h0000_0088;
    localparam csr_data_t MSTATUS_RFIXED      = 32'h0000_1800;
    localparam csr_data_t MIE_WMASK           = 32'h0000_0888;
    localparam csr_data_t MTVEC_WMASK         = 32'hFFFF_FFFC;
    localparam csr_data_t MCOUNTINHIBIT_WMASK = 32'h0000_0005;
    localparam csr_data_t MEPC_WMASK          = 32'hFFFF_FFFC;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int INHIBIT_CY_BIT   = 0;
    localparam int INHIBIT_IR_BIT   = 2;

    // True for addresses whose contents software can change
    function automatic logic csr_is_writable(input csr_addr_t addr);
        case (addr)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MCOUNTINHIBIT, CSR_MSCRATCH,
            CSR_MEPC, CSR_MCAUSE, CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET,
            CSR_MINSTRETH: return 1'b1;
            default:       return 1'b0;
        endcase
    endfunction

    // Value a write would leave behind, as seen by a subsequent read
    function automatic csr_data_t csr_write_value(input csr_addr_t addr, input csr_data_t data);
        case (addr)
            CSR_MSTATUS:       return (data & MSTATUS_WMASK) | MSTATUS_RFIXED;
            CSR_MIE:           return data & MIE_WMASK;
            CSR_MTVEC:         return data & MTVEC_WMASK;
            CSR_MCOUNTINHIBIT: return data & MCOUNTINHIBIT_WMASK;
            CSR_MEPC:          return data & MEPC_WMASK;
            CSR_MSCRATCH, CSR_MCAUSE, CSR_MCYCLE, CSR_MCYCLEH,
            CSR_MINSTRET, CSR_MINSTRETH: return data;
            default:           return '0;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with inhibit, increment enable and 32-bit half-word writes.
// A write to either half suppresses the increment for the whole counter.
module csr_counter64
    import csr_regfile_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  inhibit_i,
    input  logic                  inc_i,
    input  logic                  we_lo_i,
    input  logic                  we_hi_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [63:0]           count_o
);

    logic [63:0] count_q;

    // Software write takes priority over counting; carry into the high half is same-cycle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else if (we_lo_i) begin
            count_q[31:0] <= wdata_i;
        end else if (we_hi_i) begin
            count_q[63:32] <= wdata_i;
        end else if (inc_i && !inhibit_i) begin
            count_q <= count_q + 64'd1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: WB-stage write port, combinational read port with
// write bypass, trap/mret state and the mcycle/minstret counters.
module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter logic [DATA_WIDTH-1:0] HART_ID     = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] MISA_VALUE  = 32'h4000_0100,
    parameter logic [DATA_WIDTH-1:0] MTVEC_RESET = 32'h0000_0000
)(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      csr_we_i,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_i,
    input  logic [DATA_WIDTH-1:0]     csr_wdata_i,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_raddr_i,
    output logic [DATA_WIDTH-1:0]     csr_rdata_o,
    output logic                      csr_rvalid_o,
    input  logic                      instret_i,
    input  logic                      trap_i,
    input  logic [DATA_WIDTH-1:0]     trap_pc_i,
    input  logic [DATA_WIDTH-1:0]     trap_cause_i,
    input  logic                      mret_i,
    output logic [DATA_WIDTH-1:0]     mtvec_o,
    output logic [DATA_WIDTH-1:0]     mepc_o,
    output logic                      mie_global_o
);

    logic            mstatus_mie_q;
    logic            mstatus_mpie_q;
    csr_data_t       mie_q;
    csr_data_t       mtvec_q;
    csr_data_t       minhibit_q;
    csr_data_t       mscratch_q;
    csr_data_t       mepc_q;
    csr_data_t       mcause_q;
    logic [63:0]     cycle_cnt;
    logic [63:0]     instret_cnt;

    csr_data_t       wr_value;
    logic            we_mstatus, we_mie, we_mtvec, we_minhibit, we_mscratch;
    logic            we_mepc, we_mcause;
    logic            we_cyc_lo, we_cyc_hi, we_ins_lo, we_ins_hi;

    csr_data_t       mstatus_rd;
    csr_data_t       stored_rd;
    logic            bypass;

    // Decode the WB write into per-register strobes and the masked write value
    always_comb begin
        we_mstatus  = 1'b0;
        we_mie      = 1'b0;
        we_mtvec    = 1'b0;
        we_minhibit = 1'b0;
        we_mscratch = 1'b0;
        we_mepc     = 1'b0;
        we_mcause   = 1'b0;
        we_cyc_lo   = 1'b0;
        we_cyc_hi   = 1'b0;
        we_ins_lo   = 1'b0;
        we_ins_hi   = 1'b0;
        wr_value    = csr_write_value(csr_waddr_i, csr_wdata_i);
        if (csr_we_i) begin
            case (csr_waddr_i)
                CSR_MSTATUS:       we_mstatus  = 1'b1;
                CSR_MIE:           we_mie      = 1'b1;
                CSR_MTVEC:         we_mtvec    = 1'b1;
                CSR_MCOUNTINHIBIT: we_minhibit = 1'b1;
                CSR_MSCRATCH:      we_mscratch = 1'b1;
                CSR_MEPC:          we_mepc     = 1'b1;
                CSR_MCAUSE:        we_mcause   = 1'b1;
                CSR_MCYCLE:        we_cyc_lo   = 1'b1;
                CSR_MCYCLEH:       we_cyc_hi   = 1'b1;
                CSR_MINSTRET:      we_ins_lo   = 1'b1;
                CSR_MINSTRETH:     we_ins_hi   = 1'b1;
                default:           ;
            endcase
        end
    end

    // mstatus interrupt-enable stack: trap beats mret beats software write
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
        end else if (trap_i) begin
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
        end else if (mret_i) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
        end else if (we_mstatus) begin
            mstatus_mie_q  <= wr_value[MSTATUS_MIE_BIT];
            mstatus_mpie_q <= wr_value[MSTATUS_MPIE_BIT];
        end
    end

    // Trap capture of mepc/mcause, overriding any same-cycle software write
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mepc_q   <= '0;
            mcause_q <= '0;
        end else if (trap_i) begin
            mepc_q   <= trap_pc_i & MEPC_WMASK;
            mcause_q <= trap_cause_i;
        end else begin
            if (we_mepc)   mepc_q   <= wr_value;
            if (we_mcause) mcause_q <= wr_value;
        end
    end

    // Plain software-written registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            minhibit_q <= '0;
            mscratch_q <= '0;
        end else begin
            if (we_mie)      mie_q      <= wr_value;
            if (we_mtvec)    mtvec_q    <= wr_value;
            if (we_minhibit) minhibit_q <= wr_value;
            if (we_mscratch) mscratch_q <= wr_value;
        end
    end

    csr_counter64 u_mcycle (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inhibit_i (minhibit_q[INHIBIT_CY_BIT]),
        .inc_i     (1'b1),
        .we_lo_i   (we_cyc_lo),
        .we_hi_i   (we_cyc_hi),
        .wdata_i   (csr_wdata_i),
        .count_o   (cycle_cnt)
    );

    csr_counter64 u_minstret (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inhibit_i (minhibit_q[INHIBIT_IR_BIT]),
        .inc_i     (instret_i),
        .we_lo_i   (we_ins_lo),
        .we_hi_i   (we_ins_hi),
        .wdata_i   (csr_wdata_i),
        .count_o   (instret_cnt)
    );

    // Combinational read mux; a pending write to the same writable address is forwarded.
    // Bypass is gated by reset so an in-flight write never shows through during reset.
    always_comb begin
        mstatus_rd                   = MSTATUS_RFIXED;
        mstatus_rd[MSTATUS_MIE_BIT]  = mstatus_mie_q;
        mstatus_rd[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
        stored_rd    = '0;
        csr_rvalid_o = 1'b1;
        case (csr_raddr_i)
            CSR_MSTATUS:                  stored_rd = mstatus_rd;
            CSR_MISA:                     stored_rd = MISA_VALUE;
            CSR_MIE:                      stored_rd = mie_q;
            CSR_MTVEC:                    stored_rd = mtvec_q;
            CSR_MCOUNTINHIBIT:            stored_rd = minhibit_q;
            CSR_MSCRATCH:                 stored_rd = mscratch_q;
            CSR_MEPC:                     stored_rd = mepc_q;
            CSR_MCAUSE:                   stored_rd = mcause_q;
            CSR_MIP:                      stored_rd = '0;
            CSR_MCYCLE, CSR_CYCLE:        stored_rd = cycle_cnt[31:0];
            CSR_MCYCLEH, CSR_CYCLEH:      stored_rd = cycle_cnt[63:32];
            CSR_MINSTRET, CSR_INSTRET:    stored_rd = instret_cnt[31:0];
            CSR_MINSTRETH, CSR_INSTRETH:  stored_rd = instret_cnt[63:32];
            CSR_MHARTID:                  stored_rd = HART_ID;
            default:                      csr_rvalid_o = 1'b0;
        endcase
        bypass = rst_i && csr_we_i && (csr_waddr_i == csr_raddr_i) &&
                 csr_is_writable(csr_raddr_i);
        csr_rdata_o = bypass ? wr_value : stored_rd;
    end

    assign mtvec_o      = mtvec_q;
    assign mepc_o       = mepc_q;
    assign mie_global_o = mstatus_mie_q;

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: directed vector table, hand-written
// counter/trap/reset sequences and random traffic against a reference model.
module tb_csr_regfile;

  localparam logic [31:0] TB_HART      = 32'h0000_0003;
  localparam logic [31:0] TB_MISA      = 32'h4000_0100;
  localparam logic [31:0] TB_MTVEC_RST = 32'h0000_0100;
  localparam int          N_RANDOM     = 400;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        csr_we_i;
  logic [11:0] csr_waddr_i;
  logic [31:0] csr_wdata_i;
  logic [11:0] csr_raddr_i;
  logic [31:0] csr_rdata_o;
  logic        csr_rvalid_o;
  logic        instret_i;
  logic        trap_i;
  logic [31:0] trap_pc_i;
  logic [31:0] trap_cause_i;
  logic        mret_i;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        mie_global_o;

  int n_vec  = 0;
  int n_miss = 0;

  csr_regfile #(
    .HART_ID     (TB_HART),
    .MISA_VALUE  (TB_MISA),
    .MTVEC_RESET (TB_MTVEC_RST)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .csr_we_i     (csr_we_i),
    .csr_waddr_i  (csr_waddr_i),
    .csr_wdata_i  (csr_wdata_i),
    .csr_raddr_i  (csr_raddr_i),
    .csr_rdata_o  (csr_rdata_o),
    .csr_rvalid_o (csr_rvalid_o),
    .instret_i    (instret_i),
    .trap_i       (trap_i),
    .trap_pc_i    (trap_pc_i),
    .trap_cause_i (trap_cause_i),
    .mret_i       (mret_i),
    .mtvec_o      (mtvec_o),
    .mepc_o       (mepc_o),
    .mie_global_o (mie_global_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // CSR contents kept as plain words keyed by address; counters as 64-bit numbers.
  logic [31:0] m_reg [logic [11:0]];
  logic [63:0] m_cyc;
  logic [63:0] m_ins;

  function automatic logic [31:0] wmask(input logic [11:0] a);
    case (a)
      12'h300: return 32'h0000_0088;
      12'h304: return 32'h0000_0888;
      12'h305: return 32'hFFFF_FFFC;
      12'h320: return 32'h0000_0005;
      12'h340: return 32'hFFFF_FFFF;
      12'h341: return 32'hFFFF_FFFC;
      12'h342: return 32'hFFFF_FFFF;
      12'hB00, 12'hB80, 12'hB02, 12'hB82: return 32'hFFFF_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] fixed_bits(input logic [11:0] a);
    case (a)
      12'h300: return 32'h0000_1800;
      12'h301: return TB_MISA;
      12'hF14: return TB_HART;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic implemented(input logic [11:0] a);
    case (a)
      12'h300, 12'h301, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341, 12'h342,
      12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02, 12'hC80,
      12'hC82, 12'hF14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_counter(input logic [11:0] a);
    return (a[11:8] == 4'hB) || (a[11:8] == 4'hC);
  endfunction

  task automatic model_reset();
    m_reg[12'h300] = 32'h0;
    m_reg[12'h304] = 32'h0;
    m_reg[12'h305] = TB_MTVEC_RST;
    m_reg[12'h320] = 32'h0;
    m_reg[12'h340] = 32'h0;
    m_reg[12'h341] = 32'h0;
    m_reg[12'h342] = 32'h0;
    m_cyc = 64'h0;
    m_ins = 64'h0;
  endtask

  task automatic model_read(input logic [11:0] a, output logic [31:0] d, output logic v);
    v = implemented(a);
    d = 32'h0;
    if (v) begin
      case (a)
        12'hB00, 12'hC00: d = m_cyc[31:0];
        12'hB80, 12'hC80: d = m_cyc[63:32];
        12'hB02, 12'hC02: d = m_ins[31:0];
        12'hB82, 12'hC82: d = m_ins[63:32];
        default: begin
          d = fixed_bits(a);
          if (wmask(a) != 32'h0) d = d | m_reg[a];
        end
      endcase
    end
    if (rst_i && csr_we_i && csr_waddr_i == a && wmask(a) != 32'h0)
      d = (csr_wdata_i & wmask(a)) | fixed_bits(a);
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_update();
    logic [31:0] nx [logic [11:0]];
    logic [31:0] old_ms;
    logic [31:0] old_inh;
    old_ms  = m_reg[12'h300];
    old_inh = m_reg[12'h320];
    nx = m_reg;
    if (csr_we_i && csr_waddr_i == 12'hB00)      m_cyc = {m_cyc[63:32], csr_wdata_i};
    else if (csr_we_i && csr_waddr_i == 12'hB80) m_cyc = {csr_wdata_i, m_cyc[31:0]};
    else if (!old_inh[0])                        m_cyc = m_cyc + 64'd1;
    if (csr_we_i && csr_waddr_i == 12'hB02)      m_ins = {m_ins[63:32], csr_wdata_i};
    else if (csr_we_i && csr_waddr_i == 12'hB82) m_ins = {csr_wdata_i, m_ins[31:0]};
    else if (instret_i && !old_inh[2])           m_ins = m_ins + 64'd1;
    if (csr_we_i && wmask(csr_waddr_i) != 32'h0 && !is_counter(csr_waddr_i))
      nx[csr_waddr_i] = csr_wdata_i & wmask(csr_waddr_i);
    if (trap_i) begin
      nx[12'h341] = trap_pc_i & 32'hFFFF_FFFC;
      nx[12'h342] = trap_cause_i;
      nx[12'h300] = old_ms[3] ? 32'h80 : 32'h0;
    end else if (mret_i) begin
      nx[12'h300] = 32'h80 | (old_ms[7] ? 32'h8 : 32'h0);
    end
    m_reg = nx;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [31:0] d;
    logic        v;
    model_read(csr_raddr_i, d, v);
    check("rdata", csr_rdata_o, d);
    check("rvalid", {31'h0, csr_rvalid_o}, {31'h0, v});
    check("mtvec_o", mtvec_o, m_reg[12'h305]);
    check("mepc_o", mepc_o, m_reg[12'h341]);
    check("mie_global_o", {31'h0, mie_global_o}, {31'h0, m_reg[12'h300][3]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic we, input logic [11:0] wa, input logic [31:0] wd,
                       input logic [11:0] ra, input logic ir, input logic tr,
                       input logic [31:0] tpc, input logic [31:0] tc, input logic mr);
    csr_we_i     = we;
    csr_waddr_i  = wa;
    csr_wdata_i  = wd;
    csr_raddr_i  = ra;
    instret_i    = ir;
    trap_i       = tr;
    trap_pc_i    = tpc;
    trap_cause_i = tc;
    mret_i       = mr;
    #1;
  endtask

  task automatic rd(input logic [11:0] ra);
    drive(1'b0, 12'h0, 32'h0, ra, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [11:0] wa, input logic [31:0] wd, input logic [11:0] ra);
    drive(1'b1, wa, wd, ra, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [11:0] raddr;
    logic [31:0] exp_rdata;
    logic        exp_rvalid;
  } vec_t;

  vec_t vecs [16];

  logic [11:0] addr_pool [21];

  initial begin
    vecs[0]  = '{1'b0, 12'h000, 32'h0000_0000, 12'h305, TB_MTVEC_RST,  1'b1};
    vecs[1]  = '{1'b0, 12'h000, 32'h0000_0000, 12'h301, TB_MISA,       1'b1};
    vecs[2]  = '{1'b0, 12'h000, 32'h0000_0000, 12'hF14, TB_HART,       1'b1};
    vecs[3]  = '{1'b0, 12'h000, 32'h0000_0000, 12'h7C0, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b1, 12'h300, 32'hFFFF_FFFF, 12'h300, 32'h0000_1888, 1'b1};
    vecs[5]  = '{1'b0, 12'h000, 32'h0000_0000, 12'h300, 32'h0000_1888, 1'b1};
    vecs[6]  = '{1'b1, 12'h305, 32'h8000_0103, 12'h305, 32'h8000_0100, 1'b1};
    vecs[7]  = '{1'b0, 12'h000, 32'h0000_0000, 12'h305, 32'h8000_0100, 1'b1};
    vecs[8]  = '{1'b1, 12'h304, 32'hFFFF_FFFF, 12'h304, 32'h0000_0888, 1'b1};
    vecs[9]  = '{1'b1, 12'h320, 32'hFFFF_FFFF, 12'h320, 32'h0000_0005, 1'b1};
    vecs[10] = '{1'b1, 12'h320, 32'h0000_0000, 12'h344, 32'h0000_0000, 1'b1};
    vecs[11] = '{1'b1, 12'h301, 32'h1234_5678, 12'h301, TB_MISA,       1'b1};
    vecs[12] = '{1'b1, 12'h7C0, 32'h0000_0001, 12'h7C0, 32'h0000_0000, 1'b0};
    vecs[13] = '{1'b1, 12'h340, 32'hDEAD_BEEF, 12'h340, 32'hDEAD_BEEF, 1'b1};
    vecs[14] = '{1'b1, 12'h341, 32'h0000_0107, 12'h341, 32'h0000_0104, 1'b1};
    vecs[15] = '{1'b1, 12'h342, 32'h8000_000B, 12'h342, 32'h8000_000B, 1'b1};

    addr_pool = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341,
                  12'h342, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00,
                  12'hC02, 12'hC80, 12'hC82, 12'hF14, 12'h7C0, 12'h000, 12'h303};

    // reset state
    rst_i = 1'b0;
    drive(1'b0, 12'h0, 32'h0, 12'h305, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdata_mtvec", csr_rdata_o, TB_MTVEC_RST);
    check("reset_mtvec_o", mtvec_o, TB_MTVEC_RST);
    check("reset_mepc_o", mepc_o, 32'h0);
    check("reset_mie", {31'h0, mie_global_o}, 32'h0);
    rst_i = 1'b1;

    // table
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr, 1'b0, 1'b0,
            32'h0, 32'h0, 1'b0);
      check($sformatf("vec%0d_rdata", i), csr_rdata_o, vecs[i].exp_rdata);
      check($sformatf("vec%0d_rvalid", i), {31'h0, csr_rvalid_o}, {31'h0, vecs[i].exp_rvalid});
      check_model();
      tick();
    end
    rd(12'h000);
    check("mie_global_after_write", {31'h0, mie_global_o}, 32'h1);
    check("mtvec_o_masked", mtvec_o, 32'h8000_0100);
    check_model();
    tick();

    // mcycle carry into high half, then inhibit
    wr(12'hB80, 32'h0, 12'hB80);
    check_model();
    tick();
    wr(12'hB00, 32'hFFFF_FFFF, 12'hB00);
    check_model();
    tick();
    rd(12'hB00);
    check("mcycle_set", csr_rdata_o, 32'hFFFF_FFFF);
    check_model();
    tick();
    rd(12'hB00);
    check("mcycle_wrap_lo", csr_rdata_o, 32'h0);
    check_model();
    tick();
    wr(12'h320, 32'h1, 12'hB80);
    check("mcycleh_carry", csr_rdata_o, 32'h1);
    check_model();
    tick();
    for (int i = 0; i < 5; i++) begin
      rd((i % 2 == 0) ? 12'hB00 : 12'hC00);
      check($sformatf("mcycle_inhibit%0d", i), csr_rdata_o, 32'h2);
      check_model();
      tick();
    end
    wr(12'h320, 32'h0, 12'h320);
    check_model();
    tick();

    // trap entry with simultaneous mepc write, then mret
    wr(12'h300, 32'h8, 12'h300);
    check_model();
    tick();
    drive(1'b1, 12'h341, 32'h1234, 12'h341, 1'b0, 1'b1, 32'h106, 32'hB, 1'b0);
    check_model();
    tick();
    rd(12'h300);
    check("trap_mstatus", csr_rdata_o, 32'h1880);
    check("trap_mepc", mepc_o, 32'h104);
    check("trap_mie", {31'h0, mie_global_o}, 32'h0);
    check_model();
    tick();
    rd(12'h342);
    check("trap_mcause", csr_rdata_o, 32'hB);
    check_model();
    tick();
    drive(1'b0, 12'h0, 32'h0, 12'h300, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check_model();
    tick();
    rd(12'h300);
    check("mret_mstatus", csr_rdata_o, 32'h1888);
    check("mret_mie", {31'h0, mie_global_o}, 32'h1);
    check_model();
    tick();
    drive(1'b0, 12'h0, 32'h0, 12'h300, 1'b0, 1'b1, 32'h200, 32'h7, 1'b1);
    check_model();
    tick();
    rd(12'h300);
    check("trap_mret_mstatus", csr_rdata_o, 32'h1880);
    check("trap_mret_mepc", mepc_o, 32'h200);
    check_model();
    tick();

    // random traffic against the model
    for (int n = 0; n < N_RANDOM; n++) begin
      drive($urandom_range(0, 1) == 1,
            addr_pool[$urandom_range(0, 20)],
            $urandom(),
            addr_pool[$urandom_range(0, 20)],
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 19) == 0,
            $urandom(),
            $urandom(),
            $urandom_range(0, 14) == 0);
      check_model();
      tick();
    end

    // asynchronous reset in the middle of a cycle with a write in flight
    wr(12'h340, 32'h55AA, 12'h340);
    check_model();
    #2;
    rst_i = 1'b0;
    #1;
    check("async_rst_mscratch", csr_rdata_o, 32'h0);
    check("async_rst_mtvec_o", mtvec_o, TB_MTVEC_RST);
    check("async_rst_mie", {31'h0, mie_global_o}, 32'h0);
    csr_we_i = 1'b0;
    @(posedge clk);
    #1;
    rst_i = 1'b1;
    model_reset();
    rd(12'h340);
    check("post_rst_mscratch", csr_rdata_o, 32'h0);
    check_model();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
- Machine-mode CSR storage for the 5-stage core; sits directly downstream of the MEM/WB pipeline register.
- Consumes its registered CSR write (csr_we/csr_waddr/csr_wdata) at the WB edge.
- Provides a combinational read port to the ID/EX CSR logic.
- Owns the trap-entry/mret state and the free-running cycle/instret counters.

Parameters:
- HART_ID, 32'h0, value returned by mhartid (0xF14).
- MISA_VALUE, 32'h40000100, read-only misa content (RV32I).
- MTVEC_RESET, 32'h00000000, mtvec value after reset.

Ports:
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_i  in  1  asynchronous reset, active-low (0 = reset).
- csr_we_i  in  1  CSR write enable, from MEM/WB csr_we_o.
- csr_waddr_i  in  `CSR_ADDR_WIDTH (12)  CSR write address.
- csr_wdata_i  in  `DATA_WIDTH (32)  CSR write data.
- csr_raddr_i  in  12  read address from ID.
- csr_rdata_o  out  32  read data, combinational.
- csr_rvalid_o  out  1  1 = csr_raddr_i is an implemented CSR.
- instret_i  in  1  one-cycle pulse per retired instruction.
- trap_i  in  1  trap entry pulse.
- trap_pc_i  in  32  PC of the trapping instruction.
- trap_cause_i  in  32  mcause value for the trap.
- mret_i  in  1  mret retirement pulse.
- mtvec_o  out  32  current mtvec, to the PC mux.
- mepc_o  out  32  current mepc, to the PC mux.
- mie_global_o  out  1  mstatus.MIE.

Behaviour:
- Reset (rst_i=0, async): all CSRs 0 except mtvec=MTVEC_RESET. Outputs therefore reset to csr_rdata_o=0 (addr-dependent), mtvec_o=MTVEC_RESET, mepc_o=0, mie_global_o=0. Reset mid-operation discards any in-flight write.
- Implemented CSRs and WARL masks:
  - mstatus 0x300: MIE[3] and MPIE[7] writable; MPP[12:11] reads 2'b11; other bits 0.
  - misa 0x301: read-only.
  - mie 0x304: bits 3, 7, 11 writable.
  - mtvec 0x305: [1:0] read 0.
  - mcountinhibit 0x320: bits 0 (CY) and 2 (IR) writable.
  - mscratch 0x340: full 32 bits.
  - mepc 0x341: [1:0] read 0.
  - mcause 0x342: full 32 bits.
  - mip 0x344: reads 0.
  - mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82: read/write.
  - cycle/cycleh 0xC00/0xC80, instret/instreth 0xC02/0xC82: read-only shadows.
  - mhartid 0xF14: HART_ID.
- Writes to read-only or unimplemented addresses are ignored.
- Read path: combinational, zero latency. Unimplemented address gives rdata=0 and rvalid=0.
- Write bypass: if csr_we_i && csr_waddr_i==csr_raddr_i and the target is writable, rdata returns the masked value that will be stored at the next edge.
- Counters:
  - mcycle (64-bit) increments every cycle unless CY inhibit=1.
  - minstret (64-bit) increments on instret_i unless IR inhibit=1.
  - A software write to either half in the same cycle wins for the whole 64-bit counter: the written half takes the data, the other half holds, and there is no increment that cycle.
  - Low-half carry into the high half is the same cycle; 0xFFFFFFFF_FFFFFFFF wraps to 0.
- Trap entry on trap_i, one edge:
  - mepc <= trap_pc_i & ~3
  - mcause <= trap_cause_i
  - MPIE <= MIE
  - MIE <= 0
- mret on mret_i: MIE <= MPIE, MPIE <= 1.
- Priority: trap_i > mret_i > CSR write, applied per register. A simultaneous CSR write to an unaffected register still occurs.
- trap_i and mret_i together: only the trap takes effect.
- mtvec_o, mepc_o and mie_global_o reflect register state (post-edge), not bypassed data.

Decomposition:
- Package/defines additions: CSR address constants (CSR_MSTATUS etc.), WARL mask constants, MSTATUS_MIE_BIT=3 and MSTATUS_MPIE_BIT=7, reuse of `DATA_WIDTH and `CSR_ADDR_WIDTH.
- One natural sub-module: csr_counter64, a 64-bit counter with inhibit, increment enable, and half-word write (lo/hi select). Instantiated twice, for mcycle and minstret.

Test Plan:
- Reset then release:
  - read 0x305 gives MTVEC_RESET; 0x301 gives 0x40000100; 0xF14 gives HART_ID.
  - read 0x7C0 gives rdata=0, rvalid=0.
- Write 0x300 with 0xFFFFFFFF:
  - next-cycle read gives 0x00001888.
  - same-cycle bypass read of 0x300 also gives 0x00001888.
  - mie_global_o=1 after the edge.
- Write mtvec 0x80000103: mtvec_o=0x80000100.
- Set mcycle to 0xFFFFFFFF (mcycleh 0), then idle 1 cycle: mcycle=0, mcycleh=1. Write 1 to mcountinhibit: mcycle holds for 5 cycles.
- trap_i with trap_pc_i=0x00000106, cause=0x0000000B, MIE=1, plus a simultaneous CSR write to mepc=0x1234:
  - mepc=0x104, mcause=0xB, MPIE=1, MIE=0.
  - Then mret_i gives MIE=1, MPIE=1.
- Assert rst_i=0 asynchronously mid-cycle with csr_we_i=1 to mscratch: mscratch reads 0 immediately and after release.
